// File: rtl/mdu_seq_pkg.sv
// ---------------------------------------------------------------------------
// mdu_seq_pkg
// Shared definitions for the integer execute slice: ALU op encodings,
// multiply/divide unit opcodes, MDU FSM state encodings and the default
// datapath width. Also holds small opcode-decode helpers used by the MDU.
// ---------------------------------------------------------------------------
package mdu_seq_pkg;

    localparam int unsigned MDU_DATA_W = 32;
    localparam int unsigned MDU_OP_W   = 3;

    // ALU operation encodings used by the neighbouring single-cycle ALU.
    typedef enum logic [3:0] {
        ALU_ADD  = 4'h0,
        ALU_SUB  = 4'h1,
        ALU_AND  = 4'h2,
        ALU_OR   = 4'h3,
        ALU_XOR  = 4'h4,
        ALU_SLL  = 4'h5,
        ALU_SRL  = 4'h6,
        ALU_SRA  = 4'h7,
        ALU_SLT  = 4'h8,
        ALU_SLTU = 4'h9
    } alu_op_e;

    // Multiply/divide opcodes; bit 2 selects the divide group.
    typedef enum logic [2:0] {
        MDU_MUL    = 3'b000,
        MDU_MULH   = 3'b001,
        MDU_MULHSU = 3'b010,
        MDU_MULHU  = 3'b011,
        MDU_DIV    = 3'b100,
        MDU_DIVU   = 3'b101,
        MDU_REM    = 3'b110,
        MDU_REMU   = 3'b111
    } mdu_op_e;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'b00,
        MDU_CALC = 2'b01,
        MDU_DONE = 2'b10
    } mdu_state_e;

    // Operand 1 is interpreted as signed for these ops.
    function automatic logic op_src1_signed(input mdu_op_e op);
        return op inside {MDU_MULH, MDU_MULHSU, MDU_DIV, MDU_REM};
    endfunction

    // Operand 2 is interpreted as signed for these ops.
    function automatic logic op_src2_signed(input mdu_op_e op);
        return op inside {MDU_MULH, MDU_DIV, MDU_REM};
    endfunction

endpackage

// File: rtl/mdu_div_core.sv
// ---------------------------------------------------------------------------
// mdu_div_core
// One combinational restoring-division step on unsigned magnitudes.
// Only compiled when MDU_SEQ_DIV_EN is defined.
//
// Ports:
//   rem_i  [DATA_W-1:0]  partial remainder (always < dvsr_i)
//   quo_i  [DATA_W-1:0]  dividend bits still to shift in (MSB first),
//                        with quotient bits accumulating at the LSB end
//   dvsr_i [DATA_W-1:0]  divisor magnitude
//   rem_o  [DATA_W-1:0]  updated partial remainder
//   quo_o  [DATA_W-1:0]  quo_i shifted left with the new quotient bit
// ---------------------------------------------------------------------------
`ifdef MDU_SEQ_DIV_EN
module mdu_div_core
    import mdu_seq_pkg::*;
#(
    parameter int unsigned DATA_W = MDU_DATA_W
) (
    input  logic [DATA_W-1:0] rem_i,
    input  logic [DATA_W-1:0] quo_i,
    input  logic [DATA_W-1:0] dvsr_i,
    output logic [DATA_W-1:0] rem_o,
    output logic [DATA_W-1:0] quo_o
);

    logic [DATA_W:0] shifted;
    logic [DATA_W:0] diff;

    always_comb begin
        shifted = {rem_i, quo_i[DATA_W-1]};
        diff    = shifted - {1'b0, dvsr_i};
        // Since rem_i < dvsr_i, shifted < 2*dvsr_i, so diff[DATA_W] is a
        // clean borrow flag and the restored value always fits DATA_W bits.
        if (!diff[DATA_W]) begin
            rem_o = diff[DATA_W-1:0];
        end else begin
            rem_o = shifted[DATA_W-1:0];
        end
        quo_o = {quo_i[DATA_W-2:0], ~diff[DATA_W]};
    end

endmodule
`endif

// File: rtl/mdu_seq.sv
// ---------------------------------------------------------------------------
// mdu_seq
// Sequential multiply/divide unit. One radix-2 step per cycle for DATA_W
// cycles; shift-add multiply inline, restoring divide via mdu_div_core.
// Signed ops run on magnitudes and the sign is applied to the final result.
//
// Configuration macro: MDU_SEQ_DIV_EN
//   defined   - DIV/DIVU/REM/REMU implemented (divide-by-zero and signed
//               overflow answered in one cycle without entering CALC)
//   undefined - divide ops return 0 after one cycle, no divider built
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   flush      abort any operation, return to IDLE, discard result
//   in_valid   request valid
//   in_ready   unit can accept a request (IDLE only)
//   op         opcode (mdu_op_e)
//   src1       operand 1 / dividend
//   src2       operand 2 / divisor
//   out_valid  result valid (DONE)
//   out_ready  consumer accepts result
//   res        result, held stable while out_valid && !out_ready
// ---------------------------------------------------------------------------
module mdu_seq
    import mdu_seq_pkg::*;
#(
    parameter int unsigned DATA_W = MDU_DATA_W,
    parameter int unsigned OP_W   = MDU_OP_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   op,
    input  logic [DATA_W-1:0] src1,
    input  logic [DATA_W-1:0] src2,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] res
);

    localparam int unsigned       CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_W - 1);

    // ---------------- state ----------------
    mdu_state_e          state_q;
    mdu_op_e             op_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [DATA_W-1:0]   dvs_q;      // multiplicand / divisor magnitude
    logic [2*DATA_W-1:0] acc_q;      // {hi, lo}: product or {remainder, quotient}
    logic                neg_q;      // negate final result
    logic                in_ready_q;
    logic                out_valid_q;
    logic [DATA_W-1:0]   res_q;

    // ---------------- accept-time decode ----------------
    mdu_op_e           op_in;
    logic              s1_neg;
    logic              s2_neg;
    logic [DATA_W-1:0] mag1;
    logic [DATA_W-1:0] mag2;
    logic              neg_d;
    logic              early_d;      // answer without entering CALC
    logic [DATA_W-1:0] early_res_d;

`ifdef MDU_SEQ_DIV_EN
    localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};
    logic div_zero;
    logic div_ovf;
`endif

    always_comb begin
        op_in  = mdu_op_e'(op);
        s1_neg = op_src1_signed(op_in) & src1[DATA_W-1];
        s2_neg = op_src2_signed(op_in) & src2[DATA_W-1];
        mag1   = s1_neg ? ('0 - src1) : src1;
        mag2   = s2_neg ? ('0 - src2) : src2;
        // Remainder follows the dividend sign; everything else the XOR.
        neg_d  = (op_in == MDU_REM) ? s1_neg : (s1_neg ^ s2_neg);
`ifdef MDU_SEQ_DIV_EN
        div_zero = (src2 == '0);
        div_ovf  = ((op_in == MDU_DIV) || (op_in == MDU_REM)) &&
                   (src1 == MOST_NEG) && (src2 == '1);
        early_d  = op_in[2] && (div_zero || div_ovf);
        if (div_zero) begin
            early_res_d = op_in[1] ? src1 : '1;
        end else if (div_ovf) begin
            early_res_d = op_in[1] ? '0 : src1;
        end else begin
            early_res_d = '0;
        end
`else
        early_d     = op_in[2];
        early_res_d = '0;
`endif
    end

    // ---------------- iterative step ----------------
    logic [DATA_W:0]     mul_sum;
    logic [2*DATA_W-1:0] mul_next;
    logic [2*DATA_W-1:0] acc_d;

    always_comb begin
        // Shift-add: add multiplicand into the high half when the current
        // multiplier bit (acc_q[0]) is set, then shift the whole thing right.
        mul_sum  = {1'b0, acc_q[2*DATA_W-1:DATA_W]} +
                   (acc_q[0] ? {1'b0, dvs_q} : '0);
        mul_next = {mul_sum, acc_q[DATA_W-1:1]};
    end

`ifdef MDU_SEQ_DIV_EN
    logic [DATA_W-1:0] div_rem;
    logic [DATA_W-1:0] div_quo;

    mdu_div_core #(
        .DATA_W (DATA_W)
    ) u_div_core (
        .rem_i  (acc_q[2*DATA_W-1:DATA_W]),
        .quo_i  (acc_q[DATA_W-1:0]),
        .dvsr_i (dvs_q),
        .rem_o  (div_rem),
        .quo_o  (div_quo)
    );

    assign acc_d = op_q[2] ? {div_rem, div_quo} : mul_next;
`else
    assign acc_d = mul_next;
`endif

    // ---------------- final result from last step ----------------
    logic [DATA_W-1:0] acc_hi;
    logic [DATA_W-1:0] acc_lo;
    logic [DATA_W-1:0] hi_neg;       // high half of -{acc_hi, acc_lo}
    logic [DATA_W-1:0] res_d;

    always_comb begin
        acc_hi = acc_d[2*DATA_W-1:DATA_W];
        acc_lo = acc_d[DATA_W-1:0];
        // -(x) = ~x + 1; the +1 carries into the high half only when lo == 0.
        hi_neg = ~acc_hi + {{(DATA_W-1){1'b0}}, (acc_lo == '0)};
        res_d  = '0;
        case (op_q)
            MDU_MUL:                       res_d = acc_lo;
            MDU_MULH, MDU_MULHSU, MDU_MULHU: res_d = neg_q ? hi_neg : acc_hi;
`ifdef MDU_SEQ_DIV_EN
            MDU_DIV, MDU_DIVU:             res_d = neg_q ? ('0 - acc_lo) : acc_lo;
            MDU_REM, MDU_REMU:             res_d = neg_q ? ('0 - acc_hi) : acc_hi;
`endif
            default:                       res_d = '0;
        endcase
    end

    // ---------------- FSM with registered outputs ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= MDU_IDLE;
            op_q        <= MDU_MUL;
            cnt_q       <= '0;
            dvs_q       <= '0;
            acc_q       <= '0;
            neg_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            res_q       <= '0;
        end else if (flush) begin
            state_q     <= MDU_IDLE;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            res_q       <= '0;
        end else begin
            case (state_q)
                MDU_IDLE: begin
                    if (in_valid && in_ready_q) begin
                        op_q       <= op_in;
                        neg_q      <= neg_d;
                        dvs_q      <= mag2;
                        // lo half: multiplier or dividend; hi half starts clear
                        acc_q      <= {{DATA_W{1'b0}}, mag1};
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        if (early_d) begin
                            state_q     <= MDU_DONE;
                            out_valid_q <= 1'b1;
                            res_q       <= early_res_d;
                        end else begin
                            state_q <= MDU_CALC;
                        end
                    end
                end
                MDU_CALC: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_q     <= MDU_DONE;
                        out_valid_q <= 1'b1;
                        res_q       <= res_d;
                    end
                end
                MDU_DONE: begin
                    if (out_ready) begin
                        state_q     <= MDU_IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= MDU_IDLE;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign res       = res_q;

endmodule

// File: tb/tb_mdu_seq.sv
// ---------------------------------------------------------------------------
// tb_mdu_seq
// Directed self-checking bench for mdu_seq at DATA_W = 32. Latency is
// counted in rising edges from the accept edge (inclusive) until out_valid
// is seen, so a full operation reads 33 and an early-out reads 1.
// Divide expectations follow the MDU_SEQ_DIV_EN build setting.
// ---------------------------------------------------------------------------
module tb_mdu_seq;
    import mdu_seq_pkg::*;

    localparam int unsigned W = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    op;
    logic [W-1:0]  src1;
    logic [W-1:0]  src2;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  res;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mdu_seq #(
        .DATA_W (W),
        .OP_W   (3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .src1      (src1),
        .src2      (src2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res       (res)
    );

    task automatic check_eq(input string tag, input logic [63:0] got,
                            input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request, wait (bounded) for the result, check it and its
    // latency, then retire it with a single out_ready pulse.
    task automatic run_op(input string tag, input mdu_op_e o,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] exp_res, input int exp_lat);
        int lat;
        check_eq({tag, "_rdy"}, in_ready, 1);
        op       = o;
        src1     = a;
        src2     = b;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat      = 1;
        while (!out_valid && lat < 100) begin
            tick();
            lat++;
        end
        check_eq({tag, "_vld"}, out_valid, 1);
        check_eq({tag, "_res"}, res, exp_res);
        check_eq({tag, "_lat"}, lat, exp_lat);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        int seen;
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op        = '0;
        src1      = '0;
        src2      = '0;
        repeat (2) tick();
        check_eq("rst_vld", out_valid, 0);
        check_eq("rst_res", res, 0);
        rst_n = 1'b1;
        tick();
        check_eq("rst_rdy", in_ready, 1);

        // ---------------- multiply ----------------
        run_op("mulhu_ff",  MDU_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
        run_op("mul_ff",    MDU_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 33);
        run_op("mul_shift", MDU_MUL,    32'h1234_5678, 32'h0000_0010, 32'h2345_6780, 33);
        run_op("mulh_neg",  MDU_MULH,   32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 33);
        run_op("mulh_min",  MDU_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);
        run_op("mulhsu_n",  MDU_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
        run_op("mulhsu_p",  MDU_MULHSU, 32'h0000_0002, 32'h8000_0000, 32'h0000_0001, 33);
        run_op("mulhu_p2",  MDU_MULHU,  32'h8000_0000, 32'h0000_0004, 32'h0000_0002, 33);

        // ---------------- divide ----------------
`ifdef MDU_SEQ_DIV_EN
        run_op("div_m7_2",  MDU_DIV,  32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 33);
        run_op("rem_m7_2",  MDU_REM,  32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 33);
        run_op("div_7_m2",  MDU_DIV,  32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33);
        run_op("rem_7_m2",  MDU_REM,  32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 33);
        run_op("divu_big",  MDU_DIVU, 32'hFFFF_FFF9, 32'h0000_0002, 32'h7FFF_FFFC, 33);
        run_op("divu_100",  MDU_DIVU, 32'd100,       32'd7,         32'd14,        33);
        run_op("remu_100",  MDU_REMU, 32'd100,       32'd7,         32'd2,         33);
        run_op("divu_z",    MDU_DIVU, 32'd5,         32'd0,         32'hFFFF_FFFF, 1);
        run_op("remu_z",    MDU_REMU, 32'd5,         32'd0,         32'd5,         1);
        run_op("div_z",     MDU_DIV,  32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFFF, 1);
        run_op("rem_ovf",   MDU_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1);
        run_op("div_ovf",   MDU_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
`else
        run_op("div_off",   MDU_DIV,  32'd8, 32'd2, 32'd0, 1);
        run_op("remu_off",  MDU_REMU, 32'd9, 32'd4, 32'd0, 1);
`endif

        // ---------------- backpressure + ignored in_valid ----------------
        check_eq("hold_rdy0", in_ready, 1);
        op       = MDU_MUL;
        src1     = 32'd6;
        src2     = 32'd7;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        op       = MDU_MULHU;
        src1     = 32'hFFFF_FFFF;
        src2     = 32'hFFFF_FFFF;
        in_valid = 1'b1;
        check_eq("busy_rdy", in_ready, 0);
        repeat (3) tick();
        in_valid = 1'b0;
        seen = 0;
        while (!out_valid && seen < 100) begin
            tick();
            seen++;
        end
        check_eq("hold_vld", out_valid, 1);
        for (int i = 0; i < 10; i++) begin
            check_eq("hold_res", res, 32'd42);
            check_eq("hold_rdy", in_ready, 0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_eq("rel_rdy", in_ready, 1);
        check_eq("rel_vld", out_valid, 0);

        // ---------------- flush mid-CALC ----------------
        op       = MDU_MULHU;
        src1     = 32'h0000_FFFF;
        src2     = 32'h0000_FFFF;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check_eq("flush_rdy", in_ready, 1);
        check_eq("flush_vld", out_valid, 0);
        check_eq("flush_res", res, 0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) seen++;
            tick();
        end
        check_eq("flush_novld", seen, 0);
        run_op("mul_3x4", MDU_MUL, 32'd3, 32'd4, 32'd12, 33);

        // ---------------- async reset mid-CALC ----------------
        op       = MDU_MUL;
        src1     = 32'd5;
        src2     = 32'd5;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (10) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_vld", out_valid, 0);
        check_eq("arst_res", res, 0);
        tick();
        rst_n = 1'b1;
        tick();
        check_eq("arst_rdy", in_ready, 1);
        run_op("mul_5x5", MDU_MUL, 32'd5, 32'd5, 32'd25, 33);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/mdu_seq.md
MDU_SEQ -- requirements
Module: mdu_seq

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning operand/result width, legal values 8..64 and even.
REQ-002 SHALL have parameter OP_W, default 3, meaning opcode width, fixed at 3.
REQ-003 SHALL have one clock and an asynchronous active-low reset; all ports are listed below, one per line, in this order.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 flush  input  1  abort any operation in progress (pipeline kill).
REQ-007 in_valid  input  1  request valid.
REQ-008 in_ready  output  1  unit can accept a request.
REQ-009 op  input  OP_W  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-010 src1  input  DATA_W  operand 1 / dividend.
REQ-011 src2  input  DATA_W  operand 2 / divisor.
REQ-012 out_valid  output  1  result valid.
REQ-013 out_ready  input  1  consumer accepts result.
REQ-014 res  output  DATA_W  result.

Function
REQ-015 SHALL implement FSM IDLE -> CALC -> DONE -> IDLE.
REQ-016 in_ready SHALL be 1 only in IDLE; a request is accepted when in_valid && in_ready, and operands and op are latched.
REQ-017 CALC SHALL run exactly DATA_W cycles, one radix-2 step per cycle; out_valid SHALL rise DATA_W+1 cycles after the accept edge.
REQ-018 MUL SHALL return the low DATA_W bits of the product; MULH/MULHSU/MULHU SHALL return the high DATA_W bits of the 2*DATA_W product with s*s, s*u and u*u signedness respectively.
REQ-019 DIV/REM SHALL truncate toward zero; the remainder sign SHALL equal the dividend sign.
REQ-020 Divide by zero SHALL give quotient all-ones and remainder = src1, and SHALL go from IDLE to DONE in 1 cycle, skipping CALC.
REQ-021 Signed overflow (src1 = most-negative, src2 = -1) SHALL give DIV = src1 and REM = 0 with 1-cycle latency.
REQ-022 In DONE, out_valid=1 and res SHALL hold stable until out_ready=1; the FSM SHALL then return to IDLE, with no back-to-back accept in the same cycle.
REQ-023 flush=1 in any state SHALL force IDLE on the next edge with out_valid=0 and the result discarded; flush SHALL take priority over accept and out_ready.
REQ-024 in_valid in a non-IDLE state SHALL be ignored, and the latched operands SHALL be unaffected.

Reset
REQ-025 rst_n=0 SHALL immediately force IDLE and in_ready=1 after release, with out_valid=0, res=0 and all datapath registers cleared, including mid-operation.

Configuration
REQ-026 SHALL use macro MDU_SEQ_DIV_EN. When defined, divide ops are implemented per REQ-019..021.
REQ-027 Without MDU_SEQ_DIV_EN, ops 1xx SHALL return res=0 via DONE after 1 cycle and no divider logic SHALL be synthesised.

Structure
REQ-028 Opcode encodings, FSM state encodings and DATA_W default SHALL live in the shared definitions package alongside the existing ALU op constants.
REQ-029 The restoring-division step SHALL be one sub-module, mdu_div_core, instantiated only under MDU_SEQ_DIV_EN; multiply SHALL be inline shift-add.

Verification
REQ-030 With DATA_W=32, MULHU 0xFFFFFFFF*0xFFFFFFFF SHALL give res=0xFFFFFFFE with out_valid 33 cycles after accept; MUL with the same operands SHALL give 0x00000001.
REQ-031 DIV -7/2 SHALL give 0xFFFFFFFD (-3) and REM -7/2 SHALL give 0xFFFFFFFF (-1).
REQ-032 DIVU 5/0 SHALL give 0xFFFFFFFF after 1 cycle; REM 0x80000000/0xFFFFFFFF SHALL give 0.
REQ-033 Holding out_ready=0 for 10 cycles in DONE SHALL keep res stable and in_ready=0; raising out_ready SHALL give in_ready=1 on the next cycle.
REQ-034 flush at CALC cycle 5 SHALL give out_valid never rising and in_ready=1 next cycle; a following MUL 3*4 SHALL give 12.
REQ-035 rst_n low mid-CALC SHALL give out_valid=0 and res=0 immediately; the build without MDU_SEQ_DIV_EN SHALL give DIV 8/2 -> res=0.
